// File: rtl/dragon_body_scheduler_pkg.sv
// Shared types and constants for the dragon body scheduler.
// DRAGON_SCHED_HEAL_QUEUE_EN widens the pending-heal latch to a 2-bit counter.
package dragon_pkg;

  localparam int DRAGON_MAX_LEN = 7;

  localparam logic [1:0] CMD_MOVE = 2'b00;
  localparam logic [1:0] CMD_HEAL = 2'b01;
  localparam logic [1:0] CMD_HIT  = 2'b10;
  localparam logic [1:0] CMD_IDLE = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_INIT   = 2'd0;
  localparam state_t ST_RUN    = 2'd1;
  localparam state_t ST_INVULN = 2'd2;
  localparam state_t ST_DEAD   = 2'd3;

`ifdef DRAGON_SCHED_HEAL_QUEUE_EN
  localparam int HEAL_W = 2;
`else
  localparam int HEAL_W = 1;
`endif

endpackage

// File: rtl/dragon_body_scheduler_if.sv
// Game-logic side bundle of the dragon body scheduler.
// master = game/collision logic, slave = scheduler.
interface dragon_body_scheduler_if;

  logic       vsync;
  logic       heal_req;
  logic       hit_req;
  logic       restart;
  logic [1:0] state_cmd;
  logic [5:0] move_counter;
  logic [2:0] length;
  logic       invuln;
  logic       dead;

  modport master (
    output vsync, heal_req, hit_req, restart,
    input  state_cmd, move_counter, length, invuln, dead
  );

  modport slave (
    input  vsync, heal_req, hit_req, restart,
    output state_cmd, move_counter, length, invuln, dead
  );

endinterface

// File: rtl/dragon_body_scheduler_tick.sv
// vsync synchroniser and rising-edge detector.
// frame_tick is high for one clk per vsync rise.
module vsync_tick_gen (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  output logic frame_tick
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= vsync;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign frame_tick = sync2_q & ~prev_q;

endmodule

// File: rtl/dragon_body_scheduler.sv
// Dragon body scheduler: INIT/RUN/INVULN/DEAD FSM issuing one-clk commands.
// Optional DRAGON_SCHED_HEAL_QUEUE_EN queues up to three heal requests.
module dragon_body_scheduler
  import dragon_pkg::*;
#(
  parameter int MAX_LEN      = DRAGON_MAX_LEN,
  parameter int INIT_LEN     = 3,
  parameter int MOVE_PERIOD  = 60,
  parameter int HIT_COOLDOWN = 30
) (
  input  logic                  clk,
  input  logic                  reset,
  dragon_body_scheduler_if.slave bus
);

  localparam logic [2:0] MAX_L   = 3'(MAX_LEN);
  localparam logic [2:0] INIT_L  = 3'(INIT_LEN);
  localparam logic [5:0] MC_LAST = 6'(MOVE_PERIOD - 1);
  localparam logic [5:0] CD_LOAD = 6'(HIT_COOLDOWN);
  localparam logic [HEAL_W-1:0] HEAL_SAT = '1;
  localparam logic [HEAL_W-1:0] HEAL_ONE = HEAL_W'(1);

  logic frame_tick;

  state_t            state_q, state_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [5:0]        mc_q, mc_d;
  logic [2:0]        len_q, len_d;
  logic [5:0]        cd_q, cd_d;
  logic              inv_q, inv_d;
  logic              pend_hit_q, pend_hit_d;
  logic [HEAL_W-1:0] pend_heal_q, pend_heal_d;

  logic live;
  logic hit_take;
  logic heal_eval;
  logic heal_take;
  logic heal_drop;

  vsync_tick_gen u_tick (
    .clk        (clk),
    .reset      (reset),
    .vsync      (bus.vsync),
    .frame_tick (frame_tick)
  );

  // HIT outranks HEAL; at most one command per frame
  assign live      = (state_q == ST_RUN) || (state_q == ST_INVULN);
  assign hit_take  = frame_tick && (state_q == ST_RUN) && pend_hit_q;
  assign heal_eval = frame_tick && live && !hit_take && (pend_heal_q != '0);
  assign heal_take = heal_eval && (len_q < MAX_L);
  assign heal_drop = heal_eval && !heal_take;

  always_comb begin
    state_d     = state_q;
    cmd_d       = CMD_IDLE;
    mc_d        = mc_q;
    len_d       = len_q;
    cd_d        = cd_q;
    inv_d       = inv_q;
    pend_hit_d  = pend_hit_q;
    pend_heal_d = pend_heal_q;

    if (frame_tick && live) begin
      mc_d = (mc_q == MC_LAST) ? 6'd0 : mc_q + 6'd1;
    end

    if (heal_take) begin
      cmd_d = CMD_HEAL;
      len_d = len_q + 3'd1;
    end

    unique case (1'b1)
      (state_q == ST_INIT): begin
        if (len_q < INIT_L) begin
          cmd_d = CMD_HEAL;
          len_d = len_q + 3'd1;
          if (len_q + 3'd1 == INIT_L) state_d = ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end
      (state_q == ST_RUN): begin
        if (hit_take) begin
          cmd_d = CMD_HIT;
          len_d = len_q - 3'd1;
          if (len_q == 3'd1) begin
            state_d = ST_DEAD;
          end else begin
            cd_d    = CD_LOAD;
            inv_d   = 1'b1;
            state_d = ST_INVULN;
          end
        end
      end
      (state_q == ST_INVULN): begin
        if (frame_tick) begin
          cd_d = cd_q - 6'd1;
          if (cd_q == 6'd1) begin
            inv_d   = 1'b0;
            state_d = ST_RUN;
          end
        end
      end
      (state_q == ST_DEAD): begin
        if (bus.restart) begin
          len_d   = 3'd0;
          mc_d    = 6'd0;
          inv_d   = 1'b0;
          state_d = ST_INIT;
        end
      end
      default: ;
    endcase

    // A request in the consuming clk re-arms its latch
    pend_hit_d = (pend_hit_q & ~hit_take)
               | (bus.hit_req & (state_q == ST_RUN));

    if (heal_take) pend_heal_d = pend_heal_d - HEAL_ONE;
    if (heal_drop) pend_heal_d = '0;
    if (bus.heal_req && live && pend_heal_d != HEAL_SAT) begin
      pend_heal_d = pend_heal_d + HEAL_ONE;
    end

    if (!live) begin
      pend_hit_d  = 1'b0;
      pend_heal_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      cmd_q       <= CMD_IDLE;
      mc_q        <= 6'd0;
      len_q       <= 3'd0;
      cd_q        <= 6'd0;
      inv_q       <= 1'b0;
      pend_hit_q  <= 1'b0;
      pend_heal_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      mc_q        <= mc_d;
      len_q       <= len_d;
      cd_q        <= cd_d;
      inv_q       <= inv_d;
      pend_hit_q  <= pend_hit_d;
      pend_heal_q <= pend_heal_d;
    end
  end

  assign bus.state_cmd    = cmd_q;
  assign bus.move_counter = mc_q;
  assign bus.length       = len_q;
  assign bus.invuln       = inv_q;
  assign bus.dead         = (state_q == ST_DEAD);

endmodule

// File: tb/tb_dragon_body_scheduler.sv
// Directed bench for dragon_body_scheduler with a command scoreboard.
// Build with DRAGON_SCHED_HEAL_QUEUE_EN to check the heal-queue variant.
module tb_dragon_body_scheduler;
  import dragon_pkg::*;

  typedef struct packed {
    logic [1:0] cmd;
    logic [2:0] len;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   errors = 0;
  int   exp_mc = 0;
  bit   live = 1'b0;
  exp_t exp_q[$];

  dragon_body_scheduler_if sif ();

  dragon_body_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] c, input int l);
    exp_t e;
    e.cmd = c;
    e.len = 3'(l);
    exp_q.push_back(e);
  endtask

  // One vsync pulse: 4 clks high, 4 clks low
  task automatic frame();
    sif.vsync = 1'b1;
    repeat (4) @(negedge clk);
    sif.vsync = 1'b0;
    repeat (4) @(negedge clk);
    if (live) exp_mc = (exp_mc + 1) % 60;
  endtask

  task automatic pulse_hit();
    sif.hit_req = 1'b1;
    @(negedge clk);
    sif.hit_req = 1'b0;
  endtask

  task automatic pulse_heal();
    sif.heal_req = 1'b1;
    @(negedge clk);
    sif.heal_req = 1'b0;
  endtask

  always @(negedge clk) begin
    if (sif.state_cmd !== CMD_IDLE) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_cmd", 8'(sif.state_cmd), 8'(CMD_IDLE));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("cmd", 8'(sif.state_cmd), 8'(e.cmd));
        chk("cmd_len", 8'(sif.length), 8'(e.len));
      end
    end
  end

  initial begin
    sif.vsync    = 1'b0;
    sif.heal_req = 1'b0;
    sif.hit_req  = 1'b0;
    sif.restart  = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_cmd", 8'(sif.state_cmd), 8'(CMD_IDLE));
    chk("rst_mc", 8'(sif.move_counter), 8'd0);
    chk("rst_len", 8'(sif.length), 8'd0);
    chk("rst_inv", 8'(sif.invuln), 8'd0);
    chk("rst_dead", 8'(sif.dead), 8'd0);

    // 1: INIT heals
    push(CMD_HEAL, 1);
    push(CMD_HEAL, 2);
    push(CMD_HEAL, 3);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    live = 1'b1;
    chk("init_len", 8'(sif.length), 8'd3);
    chk("init_cmd", 8'(sif.state_cmd), 8'(CMD_IDLE));
    chk("init_drain", 8'(exp_q.size()), 8'd0);

    // 2: movement counter
    for (int f = 1; f <= 130; f++) begin
      frame();
      chk("mc_run", 8'(sif.move_counter), 8'(exp_mc));
    end

    // 3: hit and cooldown, ignored second hit
    pulse_hit();
    push(CMD_HIT, 2);
    frame();
    chk("hit_len", 8'(sif.length), 8'd2);
    chk("hit_inv", 8'(sif.invuln), 8'd1);
    for (int k = 1; k <= 30; k++) begin
      if (k == 10) pulse_hit();
      frame();
      chk("cool_inv", 8'(sif.invuln), (k < 30) ? 8'd1 : 8'd0);
    end
    frame();
    chk("cool_len", 8'(sif.length), 8'd2);
    chk("cool_mc", 8'(sif.move_counter), 8'(exp_mc));
    pulse_heal();
    push(CMD_HEAL, 3);
    frame();
    chk("heal_len", 8'(sif.length), 8'd3);

    // 4: simultaneous hit and heal
    sif.heal_req = 1'b1;
    sif.hit_req  = 1'b1;
    @(negedge clk);
    sif.heal_req = 1'b0;
    sif.hit_req  = 1'b0;
    push(CMD_HIT, 2);
    frame();
    chk("both_hit_len", 8'(sif.length), 8'd2);
    push(CMD_HEAL, 3);
    frame();
    chk("both_heal_len", 8'(sif.length), 8'd3);
    repeat (29) frame();
    chk("both_inv", 8'(sif.invuln), 8'd0);

    // 5: burst of heal requests at length 5
    pulse_heal();
    push(CMD_HEAL, 4);
    frame();
    pulse_heal();
    push(CMD_HEAL, 5);
    frame();
    repeat (4) pulse_heal();
`ifdef DRAGON_SCHED_HEAL_QUEUE_EN
    push(CMD_HEAL, 6);
    frame();
    push(CMD_HEAL, 7);
    frame();
    frame();
    chk("burst_len", 8'(sif.length), 8'd7);
`else
    push(CMD_HEAL, 6);
    frame();
    frame();
    chk("burst_len", 8'(sif.length), 8'd6);
`endif
    chk("burst_drain", 8'(exp_q.size()), 8'd0);

    // Reset mid-INIT aborts the pulse in flight
    reset = 1'b0;
    @(negedge clk);
    push(CMD_HEAL, 1);
    reset = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_cmd", 8'(sif.state_cmd), 8'(CMD_IDLE));
    chk("mid_len", 8'(sif.length), 8'd0);
    chk("mid_mc", 8'(sif.move_counter), 8'd0);
    chk("mid_inv", 8'(sif.invuln), 8'd0);
    chk("mid_dead", 8'(sif.dead), 8'd0);
    @(negedge clk);
    push(CMD_HEAL, 1);
    push(CMD_HEAL, 2);
    push(CMD_HEAL, 3);
    reset = 1'b1;
    exp_mc = 0;
    repeat (6) @(negedge clk);
    chk("reinit_len", 8'(sif.length), 8'd3);

    // 6: three hits to death, then restart
    for (int h = 1; h <= 3; h++) begin
      pulse_hit();
      push(CMD_HIT, 3 - h);
      frame();
      if (h == 3) live = 1'b0;
      chk("kill_len", 8'(sif.length), 8'(3 - h));
      if (h < 3) begin
        repeat (30) frame();
        chk("kill_inv", 8'(sif.invuln), 8'd0);
      end
    end
    chk("dead", 8'(sif.dead), 8'd1);
    chk("dead_inv", 8'(sif.invuln), 8'd0);
    for (int d = 0; d < 2; d++) begin
      pulse_heal();
      pulse_hit();
      frame();
    end
    chk("dead_cmd", 8'(sif.state_cmd), 8'(CMD_IDLE));
    chk("dead_mc", 8'(sif.move_counter), 8'(exp_mc));
    chk("dead_len", 8'(sif.length), 8'd0);
    push(CMD_HEAL, 1);
    push(CMD_HEAL, 2);
    push(CMD_HEAL, 3);
    sif.restart = 1'b1;
    @(negedge clk);
    sif.restart = 1'b0;
    repeat (6) @(negedge clk);
    chk("rs_len", 8'(sif.length), 8'd3);
    chk("rs_dead", 8'(sif.dead), 8'd0);
    chk("rs_mc", 8'(sif.move_counter), 8'd0);
    chk("final_drain", 8'(exp_q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
